rv32i_core: RTL and testbench

- Single-cycle RV32I processor with private instruction memory and data memory, both inside the block.
- Top-level compute core of the design. The bench preloads programs and data by hierarchical access to instances im.mem and dm.mem.
- The bench checks results by reading data memory.
- Program completion is signalled by software writing 0xFF to data byte 0xFFFC.

---
 rtl/rv32i_core.sv | 256 +++++++++++++++++++++++++
 tb/tb_rv32i_core.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rv32i_core (with helper rv32i_core_mem)                   |
// | Purpose  : Single-cycle RV32I processor with private byte-wide       |
// |            instruction memory (im) and data memory (dm).             |
// | Option   : CSR_COUNTER_EN adds cycle/instret counters readable by    |
// |            the Zicsr read instructions; otherwise SYSTEM is a NOP.   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+

// Byte-addressed memory. There is one combinational 4-byte read port and
// one 4-lane write port. Lane k touches byte (addr + k). The index is AW
// bits wide, so accesses wrap at the top of the array. This relies on
// MEM_BYTES being a power of two.
module rv32i_core_mem #(
  parameter int MEM_BYTES = 65536,
  parameter int AW        = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    wen_i
);
  logic [7:0] mem [0:MEM_BYTES-1];

  for (genvar k = 0; k < 4; k++) begin : g_rd_lane
    logic [AW-1:0] w_idx;
    assign w_idx               = raddr_i + AW'(k);
    assign rdata_o[8*k +: 8]   = mem[w_idx];
  end

  // Little-endian lane writes; the memory is never cleared by reset
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wen_i[k]) mem[waddr_i + AW'(k)] <= wdata_i[8*k +: 8];
    end
  end
endmodule

module rv32i_core #(
  parameter int          MEM_BYTES = 65536,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst
);
  localparam int AW = $clog2(MEM_BYTES);

  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_REG    = 7'b0110011;
  localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

  logic [31:0] pc_q, pc_d;
  logic [31:0] rf_q [0:31];

  logic [31:0] w_instr, w_dm_rdata;
  logic [6:0]  w_opcode;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3;
  logic        w_alt;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_rs1_val, w_rs2_val;
  logic [31:0] w_alu_b, w_alu_res;
  logic [4:0]  w_shamt;
  logic [AW-1:0] w_mem_addr;
  logic [3:0]  w_dm_wen;
  logic        w_br_taken;
  logic        w_rd_we;
  logic [31:0] w_rd_wdata;
  logic [31:0] w_pc_plus4;

  rv32i_core_mem #(.MEM_BYTES(MEM_BYTES)) im (
    .clk     (clk),
    .raddr_i (pc_q[AW-1:0]),
    .rdata_o (w_instr),
    .waddr_i ({AW{1'b0}}),
    .wdata_i (32'h0),
    .wen_i   (4'b0000)
  );

  rv32i_core_mem #(.MEM_BYTES(MEM_BYTES)) dm (
    .clk     (clk),
    .raddr_i (w_mem_addr),
    .rdata_o (w_dm_rdata),
    .waddr_i (w_mem_addr),
    .wdata_i (w_rs2_val),
    .wen_i   (w_dm_wen)
  );

  // Field and immediate decode
  assign w_opcode = w_instr[6:0];
  assign w_rd     = w_instr[11:7];
  assign w_f3     = w_instr[14:12];
  assign w_rs1    = w_instr[19:15];
  assign w_rs2    = w_instr[24:20];
  assign w_alt    = w_instr[30];
  assign w_imm_i  = {{20{w_instr[31]}}, w_instr[31:20]};
  assign w_imm_s  = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
  assign w_imm_b  = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
  assign w_imm_u  = {w_instr[31:12], 12'h000};
  assign w_imm_j  = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};

  assign w_rs1_val  = (w_rs1 == 5'd0) ? 32'h0 : rf_q[w_rs1];
  assign w_rs2_val  = (w_rs2 == 5'd0) ? 32'h0 : rf_q[w_rs2];
  assign w_pc_plus4 = pc_q + 32'd4;

  // Loads and stores share one address; only the low AW bits reach memory
  assign w_mem_addr = AW'(w_rs1_val + ((w_opcode == c_OP_STORE) ? w_imm_s : w_imm_i));

  assign w_alu_b = (w_opcode == c_OP_REG) ? w_rs2_val : w_imm_i;
  assign w_shamt = w_alu_b[4:0];

`ifdef CSR_COUNTER_EN
  logic [63:0] cycle_q, instret_q;
  logic [31:0] w_csr_rdata;

  // Every non-reset edge is a cycle and retires exactly one instruction
  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_q   <= 64'd0;
      instret_q <= 64'd0;
    end else begin
      cycle_q   <= cycle_q + 64'd1;
      instret_q <= instret_q + 64'd1;
    end
  end

  // Read-only counter CSRs; any other CSR address reads as zero
  always_comb begin
    w_csr_rdata = 32'h0;
    case (w_instr[31:20])
      12'hC00: w_csr_rdata = cycle_q[31:0];
      12'hC80: w_csr_rdata = cycle_q[63:32];
      12'hC02: w_csr_rdata = instret_q[31:0];
      12'hC82: w_csr_rdata = instret_q[63:32];
      default: w_csr_rdata = 32'h0;
    endcase
  end
`endif

  // Integer ALU shared by OP and OP-IMM; bit 30 selects SUB only for OP
  always_comb begin
    w_alu_res = 32'h0;
    case (w_f3)
      3'b000: w_alu_res = (w_opcode == c_OP_REG && w_alt) ? (w_rs1_val - w_alu_b)
                                                          : (w_rs1_val + w_alu_b);
      3'b001: w_alu_res = w_rs1_val << w_shamt;
      3'b010: w_alu_res = {31'h0, $signed(w_rs1_val) < $signed(w_alu_b)};
      3'b011: w_alu_res = {31'h0, w_rs1_val < w_alu_b};
      3'b100: w_alu_res = w_rs1_val ^ w_alu_b;
      3'b101: w_alu_res = w_alt ? 32'($signed(w_rs1_val) >>> w_shamt)
                                : (w_rs1_val >> w_shamt);
      3'b110: w_alu_res = w_rs1_val | w_alu_b;
      default: w_alu_res = w_rs1_val & w_alu_b;
    endcase
  end

  // Branch condition; the two unused funct3 codes never branch
  always_comb begin
    w_br_taken = 1'b0;
    case (w_f3)
      3'b000: w_br_taken = (w_rs1_val == w_rs2_val);
      3'b001: w_br_taken = (w_rs1_val != w_rs2_val);
      3'b100: w_br_taken = ($signed(w_rs1_val) <  $signed(w_rs2_val));
      3'b101: w_br_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val));
      3'b110: w_br_taken = (w_rs1_val <  w_rs2_val);
      3'b111: w_br_taken = (w_rs1_val >= w_rs2_val);
      default: w_br_taken = 1'b0;
    endcase
  end

  // Store lane enables; suppressed while reset is asserted
  always_comb begin
    w_dm_wen = 4'b0000;
    if (rst && w_opcode == c_OP_STORE) begin
      case (w_f3)
        3'b000:  w_dm_wen = 4'b0001;
        3'b001:  w_dm_wen = 4'b0011;
        3'b010:  w_dm_wen = 4'b1111;
        default: w_dm_wen = 4'b0000;
      endcase
    end
  end

  // Next PC and writeback selection; anything unrecognised falls through as a NOP
  always_comb begin
    pc_d       = w_pc_plus4;
    w_rd_we    = 1'b0;
    w_rd_wdata = 32'h0;
    case (w_opcode)
      c_OP_LUI:   begin w_rd_we = 1'b1; w_rd_wdata = w_imm_u; end
      c_OP_AUIPC: begin w_rd_we = 1'b1; w_rd_wdata = pc_q + w_imm_u; end
      c_OP_JAL: begin
        w_rd_we    = 1'b1;
        w_rd_wdata = w_pc_plus4;
        pc_d       = pc_q + w_imm_j;
      end
      c_OP_JALR: begin
        if (w_f3 == 3'b000) begin
          w_rd_we    = 1'b1;
          w_rd_wdata = w_pc_plus4;
          pc_d       = (w_rs1_val + w_imm_i) & 32'hFFFF_FFFE;
        end
      end
      c_OP_BRANCH: begin
        if (w_br_taken) pc_d = pc_q + w_imm_b;
      end
      c_OP_LOAD: begin
        w_rd_we = 1'b1;
        case (w_f3)
          3'b000:  w_rd_wdata = {{24{w_dm_rdata[7]}}, w_dm_rdata[7:0]};
          3'b001:  w_rd_wdata = {{16{w_dm_rdata[15]}}, w_dm_rdata[15:0]};
          3'b010:  w_rd_wdata = w_dm_rdata;
          3'b100:  w_rd_wdata = {24'h0, w_dm_rdata[7:0]};
          3'b101:  w_rd_wdata = {16'h0, w_dm_rdata[15:0]};
          default: w_rd_we    = 1'b0;
        endcase
      end
      c_OP_IMM, c_OP_REG: begin w_rd_we = 1'b1; w_rd_wdata = w_alu_res; end
      c_OP_SYSTEM: begin
`ifdef CSR_COUNTER_EN
        if (w_f3 != 3'b000 && w_f3 != 3'b100) begin
          w_rd_we    = 1'b1;
          w_rd_wdata = w_csr_rdata;
        end
`endif
      end
      default: pc_d = w_pc_plus4;
    endcase
  end

  // Program counter
  always_ff @(posedge clk) begin
    if (!rst) pc_q <= RESET_PC;
    else      pc_q <= pc_d;
  end

  // Register file write port; x0 is never written
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
    end else if (w_rd_we && w_rd != 5'd0) begin
      rf_q[w_rd] <= w_rd_wdata;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_rv32i_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_rv32i_core                                             |
// | Purpose  : Self-checking bench for rv32i_core. Small programs are    |
// |            assembled into im, expected dm words are queued, then     |
// |            compared once software writes the done marker.            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_rv32i_core;
  localparam logic [6:0] c_OPI = 7'h13, c_OPR = 7'h33, c_LD = 7'h03, c_ST = 7'h23;
  localparam logic [6:0] c_LUI = 7'h37, c_AUIPC = 7'h17, c_JALR = 7'h67, c_SYS = 7'h73;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rv32i_core #(.MEM_BYTES(65536), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst));

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] pc_a;
  logic [31:0] q_addr[$];
  logic [31:0] q_exp[$];
  string       q_tag[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [31:0] imm);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [31:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], c_ST};
  endfunction
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [31:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [19:0] imm);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, c_OPR};
  endfunction

  // ---------------- memory helpers ----------------
  task automatic emit(input logic [31:0] w);
    for (int k = 0; k < 4; k++) dut.im.mem[pc_a[15:0] + 16'(k)] = w[8*k +: 8];
    pc_a = pc_a + 32'd4;
  endtask
  task automatic addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
    emit(enc_i(c_OPI, rd, 3'd0, rs1, imm));
  endtask
  task automatic sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [31:0] imm);
    emit(enc_s(3'd2, rs2, rs1, imm));
  endtask
  task automatic dm_set(input logic [15:0] a, input logic [31:0] v);
    for (int k = 0; k < 4; k++) dut.dm.mem[a + 16'(k)] = v[8*k +: 8];
  endtask
  function automatic logic [31:0] dm_word(input logic [15:0] a);
    return {dut.dm.mem[a + 16'd3], dut.dm.mem[a + 16'd2], dut.dm.mem[a + 16'd1], dut.dm.mem[a]};
  endfunction
  task automatic exp_word(input string t, input logic [31:0] a, input logic [31:0] e);
    q_tag.push_back(t);
    q_addr.push_back(a);
    q_exp.push_back(e);
  endtask

  // Clear program space and the done marker, restart assembly at 0
  task automatic prep();
    for (int i = 0; i < 2048; i++) dut.im.mem[16'(i)] = 8'h00;
    dut.dm.mem[16'hFFFC] = 8'h00;
    pc_a = 32'h0;
  endtask
  // Done marker: x31=0xFF stored to byte -4 (wraps to 0xFFFC), then self loop
  task automatic done_seq();
    addi(5'd31, 5'd0, 32'd255);
    emit(enc_s(3'd0, 5'd31, 5'd0, -32'sd4));
    emit(enc_j(32'h0, 5'd0));
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask
  task automatic drain(input string tag);
    while (q_addr.size() > 0) begin
      logic [31:0] a, e;
      string t;
      a = q_addr.pop_front();
      e = q_exp.pop_front();
      t = q_tag.pop_front();
      check($sformatf("%s:%s", tag, t), dm_word(a[15:0]), e);
    end
  endtask
  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (dut.dm.mem[16'hFFFC] !== 8'hFF && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":done"}, {24'h0, dut.dm.mem[16'hFFFC]}, 32'h0000_00FF);
    drain(tag);
  endtask

  task automatic br_flag(input string t, input logic [2:0] f3, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] a, input bit taken);
    addi(5'd5, 5'd0, 32'd0);
    emit(enc_b(f3, rs1, rs2, 32'd8));
    addi(5'd5, 5'd0, 32'd1);
    sw(5'd5, 5'd0, a);
    exp_word(t, a, taken ? 32'd0 : 32'd1);
  endtask

  int          sort_in [8] = '{5, -3, 100, 0, -200, 7, 7, 42};
  int          sort_gold [8] = '{-200, -3, 0, 5, 7, 7, 42, 100};
  logic [31:0] pj, pk;

  task automatic load_sort_data();
    for (int i = 0; i < 8; i++) dm_set(16'h9000 + 16'(4*i), sort_in[i]);
    dut.dm.mem[16'hFFFC] = 8'h00;
  endtask
  task automatic push_sort_gold();
    for (int i = 0; i < 8; i++)
      exp_word($sformatf("sorted[%0d]", i), 32'h9000 + 32'(4*i), sort_gold[i]);
  endtask

  initial begin
    // ---------- reset, fetch, arithmetic ----------
    prep();
    dm_set(16'h0100, 32'h0);
    dm_set(16'h0104, 32'hDEAD_BEEF);
    addi(5'd1, 5'd0, 32'd5);
    addi(5'd2, 5'd1, -32'sd7);
    sw(5'd2, 5'd0, 32'h100);
    addi(5'd0, 5'd0, 32'd7);
    sw(5'd0, 5'd0, 32'h104);
    done_seq();
    reset_pulse();
    check("reset_pc", dut.pc_q, 32'h0);
    repeat (3) @(negedge clk);
    check("addi_3cyc", dm_word(16'h0100), 32'hFFFF_FFFE);
    exp_word("x0_zero", 32'h104, 32'h0);
    wait_done("arith", 200);

    // ---------- loads and stores ----------
    prep();
    dm_set(16'h0200, 32'h8081_F0FF);
    dm_set(16'h0204, 32'h0000_0012);
    for (int i = 0; i < 4; i++) dm_set(16'h0320 + 16'(4*i), 32'h0);
    emit(enc_i(c_LD, 5'd1, 3'd0, 5'd0, 32'h200)); sw(5'd1, 5'd0, 32'h300);
    emit(enc_i(c_LD, 5'd1, 3'd4, 5'd0, 32'h200)); sw(5'd1, 5'd0, 32'h304);
    emit(enc_i(c_LD, 5'd1, 3'd1, 5'd0, 32'h202)); sw(5'd1, 5'd0, 32'h308);
    emit(enc_i(c_LD, 5'd1, 3'd5, 5'd0, 32'h202)); sw(5'd1, 5'd0, 32'h30C);
    emit(enc_i(c_LD, 5'd1, 3'd2, 5'd0, 32'h200)); sw(5'd1, 5'd0, 32'h310);
    emit(enc_i(c_LD, 5'd1, 3'd1, 5'd0, 32'h200)); sw(5'd1, 5'd0, 32'h314);
    emit(enc_i(c_LD, 5'd1, 3'd2, 5'd0, 32'h201)); sw(5'd1, 5'd0, 32'h318);
    emit(enc_i(c_LD, 5'd1, 3'd0, 5'd0, 32'h201)); sw(5'd1, 5'd0, 32'h31C);
    emit(enc_u(c_LUI, 5'd2, 20'hA1B2C));
    addi(5'd2, 5'd2, 32'h3D4);
    emit(enc_s(3'd0, 5'd2, 5'd0, 32'h320));
    emit(enc_s(3'd1, 5'd2, 5'd0, 32'h325));
    emit(enc_s(3'd2, 5'd2, 5'd0, 32'h32A));
    done_seq();
    exp_word("lb",      32'h300, 32'hFFFF_FFFF);
    exp_word("lbu",     32'h304, 32'h0000_00FF);
    exp_word("lh",      32'h308, 32'hFFFF_8081);
    exp_word("lhu",     32'h30C, 32'h0000_8081);
    exp_word("lw",      32'h310, 32'h8081_F0FF);
    exp_word("lh_lo",   32'h314, 32'hFFFF_F0FF);
    exp_word("lw_mis",  32'h318, 32'h1280_81F0);
    exp_word("lb_mis",  32'h31C, 32'hFFFF_FFF0);
    exp_word("sb",      32'h320, 32'h0000_00D4);
    exp_word("sh_mis",  32'h324, 32'h00C3_D400);
    exp_word("sw_mis0", 32'h328, 32'hC3D4_0000);
    exp_word("sw_mis1", 32'h32C, 32'h0000_A1B2);
    reset_pulse();
    wait_done("mem", 200);

    // ---------- branches and jumps ----------
    prep();
    addi(5'd1, 5'd0, -32'sd1);
    addi(5'd2, 5'd0, 32'd1);
    br_flag("beq_t",  3'd0, 5'd2, 5'd2, 32'h400, 1'b1);
    br_flag("bne_n",  3'd1, 5'd2, 5'd2, 32'h404, 1'b0);
    br_flag("blt_t",  3'd4, 5'd1, 5'd2, 32'h408, 1'b1);
    br_flag("bge_n",  3'd5, 5'd1, 5'd2, 32'h40C, 1'b0);
    br_flag("bltu_n", 3'd6, 5'd1, 5'd2, 32'h410, 1'b0);
    br_flag("bgeu_t", 3'd7, 5'd1, 5'd2, 32'h414, 1'b1);
    br_flag("bne_t",  3'd1, 5'd1, 5'd2, 32'h418, 1'b1);
    br_flag("beq_n",  3'd0, 5'd1, 5'd2, 32'h41C, 1'b0);
    pj = pc_a;
    emit(enc_j(32'd8, 5'd7));
    addi(5'd7, 5'd0, 32'd0);
    sw(5'd7, 5'd0, 32'h440);
    exp_word("jal_link", 32'h440, pj + 32'd4);
    pk = pc_a;
    addi(5'd8, 5'd0, pk + 32'd17);
    emit(enc_i(c_JALR, 5'd8, 3'd0, 5'd8, 32'd0));
    addi(5'd9, 5'd0, 32'd1);
    addi(5'd9, 5'd0, 32'd2);
    sw(5'd8, 5'd0, 32'h444);
    sw(5'd9, 5'd0, 32'h448);
    exp_word("jalr_link", 32'h444, pk + 32'd8);
    exp_word("jalr_skip", 32'h448, 32'd0);
    pj = pc_a;
    emit(enc_u(c_AUIPC, 5'd10, 20'h00001));
    sw(5'd10, 5'd0, 32'h44C);
    exp_word("auipc", 32'h44C, pj + 32'h1000);
    done_seq();
    reset_pulse();
    wait_done("branch", 300);

    // ---------- shifts, compares, NOP opcode ----------
    prep();
    emit(enc_u(c_LUI, 5'd1, 20'h80000));
    emit(enc_i(c_OPI, 5'd2, 3'd5, 5'd1, 32'h404)); sw(5'd2, 5'd0, 32'h500);
    emit(enc_i(c_OPI, 5'd3, 3'd5, 5'd1, 32'h004)); sw(5'd3, 5'd0, 32'h504);
    addi(5'd4, 5'd0, 32'd33);
    addi(5'd5, 5'd0, 32'd3);
    emit(enc_r(7'h00, 5'd4, 5'd5, 3'd1, 5'd6));    sw(5'd6, 5'd0, 32'h508);
    emit(enc_i(c_OPI, 5'd7, 3'd3, 5'd0, -32'sd1)); sw(5'd7, 5'd0, 32'h50C);
    emit(enc_r(7'h00, 5'd0, 5'd1, 3'd2, 5'd8));    sw(5'd8, 5'd0, 32'h510);
    emit(enc_r(7'h00, 5'd0, 5'd1, 3'd3, 5'd9));    sw(5'd9, 5'd0, 32'h514);
    emit(enc_r(7'h20, 5'd4, 5'd5, 3'd0, 5'd10));   sw(5'd10, 5'd0, 32'h518);
    emit(enc_r(7'h20, 5'd4, 5'd1, 3'd5, 5'd11));   sw(5'd11, 5'd0, 32'h51C);
    emit(enc_i(c_OPI, 5'd12, 3'd4, 5'd1, -32'sd1)); sw(5'd12, 5'd0, 32'h520);
    emit(enc_i(c_OPI, 5'd13, 3'd2, 5'd1, 32'd1));  sw(5'd13, 5'd0, 32'h524);
    addi(5'd3, 5'd0, 32'h55);
    emit(32'h0000_01FF);
    emit(32'h0000_0073);
    sw(5'd3, 5'd0, 32'h528);
    done_seq();
    exp_word("srai",   32'h500, 32'hF800_0000);
    exp_word("srli",   32'h504, 32'h0800_0000);
    exp_word("sll33",  32'h508, 32'h0000_0006);
    exp_word("sltiu",  32'h50C, 32'h0000_0001);
    exp_word("slt",    32'h510, 32'h0000_0001);
    exp_word("sltu",   32'h514, 32'h0000_0000);
    exp_word("sub",    32'h518, 32'hFFFF_FFE2);
    exp_word("sra33",  32'h51C, 32'hC000_0000);
    exp_word("xori",   32'h520, 32'h7FFF_FFFF);
    exp_word("slti",   32'h524, 32'h0000_0001);
    exp_word("undef_nop", 32'h528, 32'h0000_0055);
    reset_pulse();
    wait_done("alu", 300);

    // ---------- counters ----------
    prep();
`ifdef CSR_COUNTER_EN
    emit(enc_i(c_SYS, 5'd1, 3'd2, 5'd0, 32'hC00));
    emit(enc_i(c_SYS, 5'd2, 3'd2, 5'd0, 32'hC00));
    emit(enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd3));
    sw(5'd3, 5'd0, 32'h600);
    addi(5'd4, 5'd0, 32'h77);
    emit(enc_i(c_SYS, 5'd4, 3'd2, 5'd0, 32'h123));
    sw(5'd4, 5'd0, 32'h604);
    exp_word("rdcycle_delta", 32'h600, 32'd1);
    exp_word("csr_other",     32'h604, 32'd0);
`else
    addi(5'd1, 5'd0, 32'h55);
    emit(enc_i(c_SYS, 5'd1, 3'd2, 5'd0, 32'hC00));
    sw(5'd1, 5'd0, 32'h600);
    exp_word("rdcycle_nop", 32'h600, 32'h55);
`endif
    done_seq();
    reset_pulse();
    wait_done("csr", 200);

    // ---------- sorting program ----------
    prep();
    emit(enc_u(c_LUI, 5'd10, 20'h00009));               // 0
    addi(5'd11, 5'd0, 32'd8);                            // 1
    addi(5'd12, 5'd0, 32'd0);                            // 2 outer
    addi(5'd13, 5'd0, 32'd1);                            // 3
    addi(5'd14, 5'd10, 32'd0);                           // 4
    emit(enc_b(3'd5, 5'd13, 5'd11, 32'd40));             // 5 inner: i>=n -> 15
    emit(enc_i(c_LD, 5'd15, 3'd2, 5'd14, 32'd0));        // 6
    emit(enc_i(c_LD, 5'd16, 3'd2, 5'd14, 32'd4));        // 7
    emit(enc_b(3'd5, 5'd16, 5'd15, 32'd16));             // 8 ordered -> 12
    sw(5'd16, 5'd14, 32'd0);                             // 9
    sw(5'd15, 5'd14, 32'd4);                             // 10
    addi(5'd12, 5'd0, 32'd1);                            // 11
    addi(5'd14, 5'd14, 32'd4);                           // 12
    addi(5'd13, 5'd13, 32'd1);                           // 13
    emit(enc_j(-32'sd36, 5'd0));                         // 14 -> 5
    emit(enc_b(3'd1, 5'd12, 5'd0, -32'sd52));            // 15 swapped -> 2
    done_seq();                                          // 16
    load_sort_data();
    push_sort_gold();
    reset_pulse();
    wait_done("sort", 50000);

    // Rerun, interrupted by a reset partway through
    load_sort_data();
    reset_pulse();
    repeat (60) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_pc",  dut.pc_q, 32'h0);
    check("midrst_x10", dut.rf_q[10], 32'h0);
    rst = 1'b1;
    push_sort_gold();
    wait_done("sort_rerun", 50000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
`default_nettype wire
